// File: rtl/sin_series_sequencer.sv
// Sequential Taylor-series sin(x) on IEEE-754 single using one shared fmult and one shared fadd.
// Optional abort input is compiled in with `define SIN_SEQ_ABORT_EN.

module fmult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res
);
  logic              sgn, nanIn, infIn, zeroIn;
  logic [47:0]       p;
  logic [24:0]       mr;
  logic signed [9:0] e;

  always_comb begin
    sgn    = a[31] ^ b[31];
    nanIn  = (&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0]);
    infIn  = &a[30:23] || &b[30:23];
    zeroIn = ~|a[30:23] || ~|b[30:23];
    p      = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e      = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
    // round to nearest even on the 24-bit significand
    if (p[47]) begin
      mr = {1'b0, p[47:24]} + {24'd0, p[23] & (|p[22:0] | p[24])};
      e  = e + 10'sd1;
    end else begin
      mr = {1'b0, p[46:23]} + {24'd0, p[22] & (|p[21:0] | p[23])};
    end
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (nanIn || (infIn && zeroIn)) res = 32'h7FC0_0000;
    else if (infIn)                 res = {sgn, 8'hFF, 23'd0};
    else if (zeroIn || e <= 10'sd0) res = {sgn, 31'd0};
    else if (e >= 10'sd255)         res = {sgn, 8'hFF, 23'd0};
    else                            res = {sgn, e[7:0], mr[22:0]};
  end
endmodule

module fadd (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res
);
  logic [31:0]       big;
  logic [30:0]       sml;
  logic [23:0]       mBig, mSml;
  logic [7:0]        d;
  logic [49:0]       sh;
  logic [26:0]       al, n;
  logic [27:0]       sum;
  logic [24:0]       mr;
  logic [4:0]        lz;
  logic signed [9:0] e;
  logic              sub;

  always_comb begin
    if (a[30:0] >= b[30:0]) begin big = a; sml = b[30:0]; end
    else                    begin big = b; sml = a[30:0]; end
    mBig = (|big[30:23]) ? {1'b1, big[22:0]} : 24'd0;
    mSml = (|sml[30:23]) ? {1'b1, sml[22:0]} : 24'd0;
    d    = big[30:23] - sml[30:23];
    // guard/round bits plus a sticky bit collecting everything shifted out
    sh   = {mSml, 26'd0} >> d;
    al   = {sh[49:24], |sh[23:0]};
    sub  = a[31] ^ b[31];
    sum  = sub ? ({1'b0, mBig, 3'd0} - {1'b0, al}) : ({1'b0, mBig, 3'd0} + {1'b0, al});
    lz   = 5'd0;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    e    = $signed({2'b0, big[30:23]});
    if (sum[27]) begin
      n = {sum[27:2], sum[1] | sum[0]};
      e = e + 10'sd1;
    end else begin
      n = sum[26:0] << lz;
      e = e - $signed({5'd0, lz});
    end
    mr = {1'b0, n[26:3]} + {24'd0, n[2] & (n[1] | n[0] | n[3])};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (&a[30:23] || &b[30:23]) begin
      if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0]) || (&a[30:23] && &b[30:23] && sub))
        res = 32'h7FC0_0000;
      else
        res = {big[31], 8'hFF, 23'd0};
    end
    else if (sum == 28'd0)  res = 32'd0;
    else if (e <= 10'sd0)   res = {big[31], 31'd0};
    else if (e >= 10'sd255) res = {big[31], 8'hFF, 23'd0};
    else                    res = {big[31], e[7:0], mr[22:0]};
  end
endmodule

module sin_series_sequencer #(
  parameter int N_TERMS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] x,
`ifdef SIN_SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SQ    = 3'd1;
  localparam logic [2:0] POW   = 3'd2;
  localparam logic [2:0] SCALE = 3'd3;
  localparam logic [2:0] ACC   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] K_LAST = 3'(N_TERMS - 1);

  logic [2:0]  state, k;
  logic [31:0] xr, x2, pow, prod, acc;
  logic [31:0] mulA, mulB, mulRes, addRes, coef;
  logic        abortReq;

`ifdef SIN_SEQ_ABORT_EN
  assign abortReq = abort;
`else
  assign abortReq = 1'b0;
`endif

  always_comb begin
    case (k)
      3'd1:    coef = 32'hBE2A_AAAB;
      3'd2:    coef = 32'h3C08_8889;
      3'd3:    coef = 32'hB950_0D01;
      3'd4:    coef = 32'h3638_EF1D;
      default: coef = 32'h0000_0000;
    endcase
    case (state)
      POW:     begin mulA = pow; mulB = x2;   end
      SCALE:   begin mulA = pow; mulB = coef; end
      default: begin mulA = xr;  mulB = xr;   end
    endcase
  end

  fmult uMul (.a(mulA), .b(mulB), .res(mulRes));
  fadd  uAdd (.a(acc),  .b(prod), .res(addRes));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      k      <= 3'd0;
      xr     <= 32'd0;
      x2     <= 32'd0;
      pow    <= 32'd0;
      prod   <= 32'd0;
      acc    <= 32'd0;
      result <= 32'd0;
    end else if (abortReq && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          xr    <= x;
          pow   <= x;
          acc   <= x;
          k     <= 3'd1;
          state <= SQ;
        end
        SQ: begin
          x2 <= mulRes;
          if (N_TERMS == 1) begin
            result <= acc;
            state  <= DONE;
          end else begin
            state <= POW;
          end
        end
        POW: begin
          pow   <= mulRes;
          state <= SCALE;
        end
        SCALE: begin
          prod  <= mulRes;
          state <= ACC;
        end
        ACC: begin
          acc <= addRes;
          // result is captured on entry to DONE so it holds until the next completion
          if (k == K_LAST) begin
            result <= addRes;
            state  <= DONE;
          end else begin
            k     <= k + 3'd1;
            state <= POW;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
